// File: rtl/mod_const_pipe.sv
// rtl/mod_const_pipe.sv - pipelined remainder of a DATA_W-bit word by constant MODULUS, elastic handshake, sideband tag.
// Optional two's-complement (floor modulo) dividend when MOD_SIGNED_EN is defined.
module mod_const_pipe #(
  parameter int DATA_W  = 32,
  parameter int MODULUS = 17,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mark_in,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          dividend,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       mark_out,
  input  logic                       out_ready,
  output logic [$clog2(MODULUS)-1:0] remainder,
  output logic [TAG_W-1:0]           tag_out
);

  localparam int REM_W   = $clog2(MODULUS);
  localparam int L       = $clog2(DATA_W);
  localparam int LATENCY = L + 5;
  localparam int MAX_SUM = DATA_W * (MODULUS - 1);
  localparam int SW      = $clog2(MAX_SUM + 1);
  localparam int NK      = MAX_SUM / MODULUS;

  // Packed table of per-bit weights 2^i mod MODULUS; the sign bit carries the negated weight.
  function automatic logic [DATA_W*SW-1:0] weights_all();
    logic [DATA_W*SW-1:0] v;
    int r;
    int w;
    v = '0;
    r = 1 % MODULUS;
    for (int i = 0; i < DATA_W; i++) begin
      w = r;
`ifdef MOD_SIGNED_EN
      if (i == DATA_W - 1) w = (MODULUS - r) % MODULUS;
`endif
      v = v | ((DATA_W*SW)'(w) << (i * SW));
      r = (r * 2) % MODULUS;
    end
    return v;
  endfunction

  localparam logic [DATA_W*SW-1:0] WGTS = weights_all();

  logic                         en;
  logic [LATENCY-1:0]           vld;
  logic [LATENCY-2:0][TAG_W-1:0] tag_pipe;
  logic [DATA_W-1:0]            data_s0;
  logic [SW-1:0]                tree     [0:L][0:DATA_W-1];
  logic [SW-1:0]                tree_nxt [0:L][0:DATA_W-1];
  logic [SW-1:0]                sum_a;
  logic [SW-1:0]                sum_b;
  logic [NK:1]                  ge;
  logic [NK:1]                  ge_nxt;
  logic [NK:1]                  onehot;
  logic [SW-1:0]                mult;
  logic [SW-1:0]                mult_nxt;

  assign en       = ~mark_out | out_ready;
  assign in_ready = en;
  assign mark_out = vld[LATENCY-1];

  for (genvar i = 0; i < DATA_W; i++) begin : g_term
    assign tree_nxt[0][i] = data_s0[i] ? WGTS[i*SW +: SW] : '0;
  end

  // Each level halves the operand count; an odd leftover passes straight through.
  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int PREV = (DATA_W + (1 << (j - 1)) - 1) >> (j - 1);
    for (genvar i = 0; i < DATA_W; i++) begin : g_node
      if (2*i + 1 < PREV) begin : g_add
        assign tree_nxt[j][i] = tree[j-1][2*i] + tree[j-1][2*i+1];
      end else if (2*i < PREV) begin : g_pass
        assign tree_nxt[j][i] = tree[j-1][2*i];
      end else begin : g_zero
        assign tree_nxt[j][i] = '0;
      end
    end
  end

  for (genvar k = 1; k <= NK; k++) begin : g_cmp
    assign ge_nxt[k] = (tree[L][0] >= SW'(k * MODULUS));
  end

  // ge is a thermometer code; its top set bit marks the largest multiple not above the sum.
  assign onehot = ge & ~(ge >> 1);

  for (genvar k = 1; k <= NK; k++) begin : g_sel
    logic [SW-1:0] acc;
    if (k == 1) begin : g_first
      assign acc = onehot[1] ? SW'(MODULUS) : '0;
    end else begin : g_next
      assign acc = g_sel[k-1].acc | (onehot[k] ? SW'(k * MODULUS) : '0);
    end
  end

  assign mult_nxt = g_sel[NK].acc;

  always_ff @(posedge clk) begin
    if (en) begin
      data_s0  <= dividend;
      tree     <= tree_nxt;
      sum_a    <= tree[L][0];
      ge       <= ge_nxt;
      sum_b    <= sum_a;
      mult     <= mult_nxt;
      tag_pipe <= {tag_pipe[LATENCY-3:0], tag_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      remainder <= '0;
      tag_out   <= '0;
    end else if (en) begin
      vld       <= {vld[LATENCY-2:0], mark_in};
      remainder <= REM_W'(sum_b - mult);
      tag_out   <= tag_pipe[LATENCY-2];
    end
  end

endmodule

// File: tb/tb_mod_const_pipe.sv
// tb/tb_mod_const_pipe.sv - scoreboard bench for mod_const_pipe (32/17 main instance, 8/3 and 8/16 side instances).
module tb_mod_const_pipe;

  localparam int DW  = 32;
  localparam int MOD = 17;
  localparam int TW  = 4;
  localparam int RW  = $clog2(MOD);
  localparam int LAT = $clog2(DW) + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          mark_in = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dividend = '0;
  logic [TW-1:0] tag_in = '0;
  logic          in_ready;
  logic          mark_out;
  logic [RW-1:0] remainder;
  logic [TW-1:0] tag_out;

  logic       b_mark = 1'b0;
  logic [7:0] b_div = '0;
  logic [3:0] b_tag = '0;
  logic       b_oready = 1'b1;
  logic       b3_ir, b3_mo, b16_ir, b16_mo;
  logic [1:0] b3_rem;
  logic [3:0] b16_rem;
  logic [3:0] b3_tag, b16_tag;

  mod_const_pipe #(.DATA_W(DW), .MODULUS(MOD), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .mark_in(mark_in), .in_ready(in_ready),
    .dividend(dividend), .tag_in(tag_in), .mark_out(mark_out), .out_ready(out_ready),
    .remainder(remainder), .tag_out(tag_out));

  mod_const_pipe #(.DATA_W(8), .MODULUS(3), .TAG_W(4)) u_m3 (
    .clk(clk), .rst_n(rst_n), .mark_in(b_mark), .in_ready(b3_ir),
    .dividend(b_div), .tag_in(b_tag), .mark_out(b3_mo), .out_ready(b_oready),
    .remainder(b3_rem), .tag_out(b3_tag));

  mod_const_pipe #(.DATA_W(8), .MODULUS(16), .TAG_W(4)) u_m16 (
    .clk(clk), .rst_n(rst_n), .mark_in(b_mark), .in_ready(b16_ir),
    .dividend(b_div), .tag_in(b_tag), .mark_out(b16_mo), .out_ready(b_oready),
    .remainder(b16_rem), .tag_out(b16_tag));

  typedef struct {
    int         rem;
    logic [3:0] tag;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  exp_t q16[$];
  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int out_cnt = 0;
  int rdy_mode = 0;

  // Mathematical residue of the w-bit word d, read as signed when the signed build is selected.
  function automatic int ref_mod(input longint unsigned d, input int w, input int m);
    longint v;
    v = longint'(d);
`ifdef MOD_SIGNED_EN
    if (((d >> (w - 1)) & 64'd1) == 64'd1) v = v - (longint'(1) << w);
`endif
    v = v % longint'(m);
    if (v < 0) v = v + longint'(m);
    return int'(v);
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(17 * $urandom_range(0, 250000000));
      default: return $urandom();
    endcase
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input bit lat);
    int waits;
    bit done;
    waits = 0;
    done = 1'b0;
    @(negedge clk);
    mark_in  = 1'b1;
    dividend = d;
    tag_in   = t;
    while (!done) begin
      #4;
      if (in_ready) begin
        q.push_back('{ref_mod(d, DW, MOD), t, cyc, lat});
        done = 1'b1;
      end else begin
        waits++;
        stalls++;
        if (waits > 1000) begin
          check("in_ready_timeout", 0, 1);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mark_in = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() + q3.size() + q16.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size() + q3.size() + q16.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  initial begin : mon_main
    bit held;
    logic [RW-1:0] h_rem;
    logic [TW-1:0] h_tag;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) check("hold", {mark_out, remainder, tag_out}, {1'b1, h_rem, h_tag});
        if (mark_out && out_ready) begin
          out_cnt++;
          if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            check("remainder", remainder, e.rem);
            check("tag", tag_out, e.tag);
            if (e.lat) check("latency", cyc, e.cyc + LAT);
          end
          held = 1'b0;
        end else if (mark_out) begin
          held  = 1'b1;
          h_rem = remainder;
          h_tag = tag_out;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : mon_side
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (b3_mo) begin
          if (q3.size() == 0) check("m3_unexpected", 1, 0);
          else begin
            e = q3.pop_front();
            check("m3_rem", b3_rem, e.rem);
            check("m3_tag", b3_tag, e.tag);
          end
        end
        if (b16_mo) begin
          if (q16.size() == 0) check("m16_unexpected", 1, 0);
          else begin
            e = q16.pop_front();
            check("m16_rem", b16_rem, e.rem);
            check("m16_tag", b16_tag, e.tag);
          end
        end
      end
    end
  end

  initial begin : main
    logic [31:0] dir [7];
    logic [7:0]  bdir [4];
    logic [7:0]  bv;
    logic [3:0]  bt;
    int s0;
    int o0;
    bit seen;
    dir  = '{32'd0, 32'd16, 32'd17, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFEF};
    bdir = '{8'd255, 8'd254, 8'h80, 8'hAB};

    repeat (3) @(negedge clk);
    #4;
    check("reset_mark_out", mark_out, 0);
    check("reset_remainder", remainder, 0);
    check("reset_tag_out", tag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    foreach (dir[i]) begin
      send(dir[i], 4'(i), 1'b1);
      idle(LAT + 2);
    end
    send(32'd17 * 32'd1000, 4'd9, 1'b1);
    idle(LAT + 2);
    wait_drain();

    s0 = stalls;
    for (int i = 0; i < 10000; i++) send(rand_word(), 4'($urandom), 1'b1);
    check("t2_stalls", stalls - s0, 0);
    idle(2);
    wait_drain();

    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) send(rand_word(), 4'($urandom), 1'b0);
    idle(2);
    rdy_mode = 0;
    wait_drain();

    for (int i = 0; i < 204; i++) begin
      bv = (i < 4) ? bdir[i] : 8'($urandom);
      bt = 4'($urandom);
      @(negedge clk);
      b_mark = 1'b1;
      b_div  = bv;
      b_tag  = bt;
      #4;
      check("side_in_ready", {b3_ir, b16_ir}, 2'b11);
      q3.push_back('{ref_mod(64'(bv), 8, 3), bt, 0, 1'b0});
      q16.push_back('{ref_mod(64'(bv), 8, 16), bt, 0, 1'b0});
    end
    @(negedge clk);
    b_mark = 1'b0;
    wait_drain();

    for (int i = 0; i < 6; i++) send(rand_word(), 4'(i), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      mark_in = 1'b0;
      #2;
      if (mark_out) seen = 1'b1;
    end
    check("t4_output_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("t4_flush_mark_out", mark_out, 0);
    check("t4_flush_remainder", remainder, 0);
    q.delete();
    o0 = out_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 5);
    check("t4_no_stale", out_cnt - o0, 0);
    send(32'd100, 4'd5, 1'b1);
    idle(LAT + 2);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
